voter_session_ctrl: RTL and testbench

Session controller for the 4-input combinational voter datapath. It collects one ballot per voter through per-voter valid/ack handshakes and drives the registered 4-bit ballot vector into the voter. It closes the session when all four voters have voted or a timeout expires, then latches the voter's 3-bit verdict and reports completion. It sits between the voter-facing request logic and the voter instance, which stays purely combinational.

---
 rtl/voter_session_ctrl.sv | 120 ++++++++++++
 tb/tb_voter_session_ctrl.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/voter_session_ctrl.sv
// Session controller for the 4-input voter: collects one ballot per voter,
// closes on full turnout or timeout, then latches the voter's verdict.
module voter_session_ctrl #(
   parameter int unsigned TIMEOUT_CYCLES = 15
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [3:0] vote_valid,
   input  logic [3:0] vote_val,
   output logic [3:0] vote_ack,
   output logic [3:0] ballot,
   output logic [3:0] cast,
   input  logic [2:0] verdict_in,
   output logic [2:0] verdict,
   output logic       result_valid,
   output logic       timed_out,
   output logic       busy
);

   localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [TW-1:0] TIMER_ONE  = TW'(1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_OPEN   = 2'd1,
      ST_SETTLE = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [3:0]    ballot_q, ballot_d;
   logic [3:0]    cast_q, cast_d;
   logic [3:0]    ack_q, ack_d;
   logic [TW-1:0] timer_q, timer_d;
   logic [2:0]    verdict_q, verdict_d;
   logic          rv_q, rv_d;
   logic          to_q, to_d;
   logic [3:0]    accept;

   // A vote is taken only while OPEN and only once per voter per session.
   for (genvar gi = 0; gi < 4; gi++) begin : g_accept
      assign accept[gi] = (state_q == ST_OPEN) && vote_valid[gi] && !cast_q[gi];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         ballot_q  <= 4'd0;
         cast_q    <= 4'd0;
         ack_q     <= 4'd0;
         timer_q   <= '0;
         verdict_q <= 3'd0;
         rv_q      <= 1'b0;
         to_q      <= 1'b0;
      end else begin
         state_q   <= state_d;
         ballot_q  <= ballot_d;
         cast_q    <= cast_d;
         ack_q     <= ack_d;
         timer_q   <= timer_d;
         verdict_q <= verdict_d;
         rv_q      <= rv_d;
         to_q      <= to_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      ballot_d  = ballot_q;
      cast_d    = cast_q;
      ack_d     = 4'd0;
      timer_d   = timer_q;
      verdict_d = verdict_q;
      rv_d      = 1'b0;
      to_d      = to_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               ballot_d = 4'd0;
               cast_d   = 4'd0;
               to_d     = 1'b0;
               timer_d  = '0;
               state_d  = ST_OPEN;
            end
         end
         ST_OPEN: begin
            ballot_d = (ballot_q & ~accept) | (vote_val & accept);
            cast_d   = cast_q | accept;
            ack_d    = accept;
            timer_d  = timer_q + TIMER_ONE;
            // Full turnout wins over expiry on the same cycle.
            if (cast_d == 4'b1111) begin
               state_d = ST_SETTLE;
               to_d    = 1'b0;
            end else if (timer_q == TIMER_LAST) begin
               state_d = ST_SETTLE;
               to_d    = 1'b1;
            end
         end
         ST_SETTLE: begin
            verdict_d = verdict_in;
            rv_d      = 1'b1;
            state_d   = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign vote_ack     = ack_q;
   assign ballot       = ballot_q;
   assign cast         = cast_q;
   assign verdict      = verdict_q;
   assign result_valid = rv_q;
   assign timed_out    = to_q;
   assign busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_voter_session_ctrl.sv
// Directed bench for voter_session_ctrl with a popcount stand-in for the voter.
module tb_voter_session_ctrl;

   logic       clk;
   logic       rst;
   logic       start;
   logic [3:0] vote_valid;
   logic [3:0] vote_val;
   logic [3:0] vote_ack;
   logic [3:0] ballot;
   logic [3:0] cast;
   logic [2:0] verdict_in;
   logic [2:0] verdict;
   logic       result_valid;
   logic       timed_out;
   logic       busy;

   int n_cmp = 0;
   int n_err = 0;

   voter_session_ctrl #(.TIMEOUT_CYCLES(15)) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .vote_valid   (vote_valid),
      .vote_val     (vote_val),
      .vote_ack     (vote_ack),
      .ballot       (ballot),
      .cast         (cast),
      .verdict_in   (verdict_in),
      .verdict      (verdict),
      .result_valid (result_valid),
      .timed_out    (timed_out),
      .busy         (busy)
   );

   assign verdict_in = 3'(ballot[0]) + 3'(ballot[1]) + 3'(ballot[2]) + 3'(ballot[3]);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; vote_valid = 4'd0; vote_val = 4'd0;
      tick(); tick();
      rst = 1'b0;
      chk("reset_ack", 32'(vote_ack), 32'h0);
      chk("reset_ballot_cast", 32'({ballot, cast}), 32'h0);
      chk("reset_verdict", 32'(verdict), 32'h0);
      chk("reset_flags", 32'({result_valid, timed_out, busy}), 32'h0);

      // votes while IDLE are ignored
      vote_valid = 4'b1111; vote_val = 4'b1111;
      tick();
      vote_valid = 4'd0;
      chk("idle_vote_ack", 32'(vote_ack), 32'h0);
      chk("idle_vote_cast", 32'(cast), 32'h0);
      chk("idle_busy", 32'(busy), 32'h0);

      // full session, all voters at once
      start = 1'b1; tick(); start = 1'b0;
      chk("full_busy_open", 32'(busy), 32'h1);
      vote_valid = 4'b1111; vote_val = 4'b1011;
      tick();
      vote_valid = 4'd0;
      chk("full_ack", 32'(vote_ack), 32'hF);
      chk("full_ballot", 32'(ballot), 32'hB);
      chk("full_cast", 32'(cast), 32'hF);
      chk("full_rv_early", 32'(result_valid), 32'h0);
      tick();
      chk("full_ack_pulse", 32'(vote_ack), 32'h0);
      chk("full_rv", 32'(result_valid), 32'h1);
      chk("full_verdict", 32'(verdict), 32'h3);
      chk("full_to", 32'(timed_out), 32'h0);
      chk("full_busy_done", 32'(busy), 32'h0);
      tick();
      chk("full_rv_pulse", 32'(result_valid), 32'h0);
      chk("full_hold", 32'({verdict, ballot}), 32'h3B);

      // duplicate vote and start during OPEN
      start = 1'b1; tick(); start = 1'b0;
      vote_valid = 4'b0001; vote_val = 4'b0001;
      tick();
      chk("dup_first_ack", 32'(vote_ack), 32'h1);
      chk("dup_first_ballot", 32'(ballot), 32'h1);
      vote_valid = 4'b0001; vote_val = 4'b0000; start = 1'b1;
      tick();
      start = 1'b0;
      chk("dup_second_ack", 32'(vote_ack), 32'h0);
      chk("dup_second_ballot", 32'(ballot), 32'h1);
      chk("open_start_ignored", 32'({busy, cast}), 32'h11);
      vote_valid = 4'b1110; vote_val = 4'b0000;
      tick();
      vote_valid = 4'd0;
      chk("dup_rest_ack", 32'(vote_ack), 32'hE);
      chk("dup_rest_cast", 32'(cast), 32'hF);
      tick();
      chk("dup_rv", 32'(result_valid), 32'h1);
      chk("dup_verdict", 32'(verdict), 32'h1);
      chk("dup_to", 32'(timed_out), 32'h0);

      // start while result_valid is high opens the timeout session
      start = 1'b1; tick(); start = 1'b0;
      chk("b2b_start_busy", 32'(busy), 32'h1);
      chk("b2b_start_clear", 32'({ballot, cast}), 32'h0);
      vote_valid = 4'b0110; vote_val = 4'b0110;
      tick();
      vote_valid = 4'd0;
      chk("to_ack", 32'(vote_ack), 32'h6);
      for (int i = 0; i < 14; i++) tick();
      chk("to_settle_rv", 32'(result_valid), 32'h0);
      chk("to_settle_busy", 32'(busy), 32'h1);
      tick();
      chk("to_rv", 32'(result_valid), 32'h1);
      chk("to_verdict", 32'(verdict), 32'h2);
      chk("to_flag", 32'(timed_out), 32'h1);
      chk("to_cast_ballot", 32'({cast, ballot}), 32'h66);
      chk("to_busy", 32'(busy), 32'h0);

      // final vote on the last OPEN cycle
      start = 1'b1; tick(); start = 1'b0;
      vote_valid = 4'b0111; vote_val = 4'b0101;
      tick();
      vote_valid = 4'd0;
      for (int i = 0; i < 13; i++) tick();
      chk("bnd_still_open", 32'({busy, result_valid}), 32'h2);
      vote_valid = 4'b1000; vote_val = 4'b1000;
      tick();
      vote_valid = 4'd0;
      chk("bnd_ack", 32'(vote_ack), 32'h8);
      chk("bnd_cast", 32'(cast), 32'hF);
      tick();
      chk("bnd_rv", 32'(result_valid), 32'h1);
      chk("bnd_to", 32'(timed_out), 32'h0);
      chk("bnd_verdict", 32'(verdict), 32'h3);

      // asynchronous abort mid-session
      start = 1'b1; tick(); start = 1'b0;
      vote_valid = 4'b0011; vote_val = 4'b0011;
      tick();
      vote_valid = 4'd0;
      chk("abort_cast_before", 32'(cast), 32'h3);
      #3 rst = 1'b1;
      #1;
      chk("abort_ballot_cast", 32'({ballot, cast}), 32'h0);
      chk("abort_busy", 32'(busy), 32'h0);
      chk("abort_verdict", 32'(verdict), 32'h0);
      tick();
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("abort_no_rv", 32'({result_valid, busy}), 32'h0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
